// File: rtl/regfile_wport_arb.sv
// regfile_wport_arb
//
// Arbitrates two writeback requesters (A: ALU, B: load/multi-cycle unit)
// onto the single register-file write port. Ties are broken round-robin
// from a registered last_grant flag, so a requester waits at most one cycle.
// The write port is registered: a handshake at edge N shows up on
// we3/wa3/wd3 during cycle N+1. Writes to the zero register (all-ones
// address) complete their handshake but never reach the register file.
//
// Ports
//   clk, reset               clock and synchronous active-high reset
//   a_valid/a_addr/a_data    requester A write request
//   a_ready                  requester A accepted this cycle
//   b_valid/b_addr/b_data    requester B write request
//   b_ready                  requester B accepted this cycle
//   we3/wa3/wd3              register-file write port
//   chk_addr/chk_hit         decode query: does the write on the port hit chk_addr
//   wr_count                 saturating count of committed writes

module regfile_wport_arb #(
  parameter int DW = 64,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          b_ready,
  output logic          we3,
  output logic [AW-1:0] wa3,
  output logic [DW-1:0] wd3,
  input  logic [AW-1:0] chk_addr,
  output logic          chk_hit,
  output logic [15:0]   wr_count
);

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_t;

  localparam logic [AW-1:0] ZERO_REG = '1;

  grant_t        last_grant;
  logic [15:0]   count_q;
  logic          a_xfer;
  logic          b_xfer;
  logic          any_xfer;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_data;

  // Grant logic: a lone requester always wins; on a tie the requester that
  // did not win last time gets ready. Nothing is accepted during reset.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (!reset) begin
      if (a_valid && (!b_valid || (last_grant == GRANT_B))) begin
        a_ready = 1'b1;
      end else if (b_valid) begin
        b_ready = 1'b1;
      end
    end
  end

  // Handshake detection and selection of the winning request's payload.
  always_comb begin
    a_xfer   = a_valid && a_ready;
    b_xfer   = b_valid && b_ready;
    any_xfer = a_xfer || b_xfer;
    sel_addr = a_xfer ? a_addr : b_addr;
    sel_data = a_xfer ? a_data : b_data;
  end

  // Registered write port, round-robin state and commit counter.
  // A zero-register write leaves wa3/wd3 untouched and is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      we3        <= 1'b0;
      wa3        <= '0;
      wd3        <= '0;
      count_q    <= 16'd0;
      last_grant <= GRANT_B;
    end else begin
      if (a_xfer) begin
        last_grant <= GRANT_A;
      end else if (b_xfer) begin
        last_grant <= GRANT_B;
      end

      if (any_xfer && (sel_addr != ZERO_REG)) begin
        we3 <= 1'b1;
        wa3 <= sel_addr;
        wd3 <= sel_data;
        if (count_q != 16'hFFFF) begin
          count_q <= count_q + 16'd1;
        end
      end else begin
        we3 <= 1'b0;
      end
    end
  end

  // Forwarding/hazard query against the write currently on the port.
  always_comb begin
    chk_hit  = we3 && (wa3 == chk_addr) && (chk_addr != ZERO_REG);
    wr_count = count_q;
  end

endmodule

// File: tb/tb_regfile_wport_arb.sv
module tb_regfile_wport_arb;

  logic        clk;
  logic        reset;
  logic        a_valid;
  logic [4:0]  a_addr;
  logic [63:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_addr;
  logic [63:0] b_data;
  logic        b_ready;
  logic        we3;
  logic [4:0]  wa3;
  logic [63:0] wd3;
  logic [4:0]  chk_addr;
  logic        chk_hit;
  logic [15:0] wr_count;

  int errorCount = 0;
  int checkCount = 0;

  regfile_wport_arb #(.DW(64), .AW(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .a_valid  (a_valid),
    .a_addr   (a_addr),
    .a_data   (a_data),
    .a_ready  (a_ready),
    .b_valid  (b_valid),
    .b_addr   (b_addr),
    .b_data   (b_data),
    .b_ready  (b_ready),
    .we3      (we3),
    .wa3      (wa3),
    .wd3      (wd3),
    .chk_addr (chk_addr),
    .chk_hit  (chk_hit),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic av, input logic [4:0] aa, input logic [63:0] ad,
                               input logic bv, input logic [4:0] ba, input logic [63:0] bd);
    a_valid = av;
    a_addr  = aa;
    a_data  = ad;
    b_valid = bv;
    b_addr  = ba;
    b_data  = bd;
    #1;
  endtask

  int expWa [4] = '{1, 5, 2, 6};
  int ai;
  int bi;

  initial begin
    reset    = 1'b1;
    chk_addr = 5'd0;
    applyStimulus(1'b1, 5'd1, 64'h1, 1'b1, 5'd2, 64'h2);
    checkOutput("rst_a_ready", 64'(a_ready), 64'd0);
    checkOutput("rst_b_ready", 64'(b_ready), 64'd0);
    tick();
    tick();
    checkOutput("rst_we3", 64'(we3), 64'd0);
    checkOutput("rst_wa3", 64'(wa3), 64'd0);
    checkOutput("rst_wd3", wd3, 64'd0);
    checkOutput("rst_count", 64'(wr_count), 64'd0);
    reset = 1'b0;
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    checkOutput("idle_a_ready", 64'(a_ready), 64'd0);
    checkOutput("idle_b_ready", 64'(b_ready), 64'd0);

    // Single A write to x14
    applyStimulus(1'b1, 5'd14, 64'hFFFF_AAAA_FFFF_CCCC, 1'b0, 5'd0, 64'd0);
    checkOutput("t1_a_ready", 64'(a_ready), 64'd1);
    checkOutput("t1_b_ready", 64'(b_ready), 64'd0);
    tick();
    chk_addr = 5'd14;
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    checkOutput("t1_we3", 64'(we3), 64'd1);
    checkOutput("t1_wa3", 64'(wa3), 64'd14);
    checkOutput("t1_wd3", wd3, 64'hFFFF_AAAA_FFFF_CCCC);
    checkOutput("t1_chk_hit", 64'(chk_hit), 64'd1);
    checkOutput("t1_count", 64'(wr_count), 64'd1);
    tick();
    checkOutput("t1_we3_drop", 64'(we3), 64'd0);
    checkOutput("t1_chk_hit_drop", 64'(chk_hit), 64'd0);

    // Zero-register write
    applyStimulus(1'b1, 5'd31, 64'h1234, 1'b0, 5'd0, 64'd0);
    checkOutput("t3_a_ready", 64'(a_ready), 64'd1);
    tick();
    chk_addr = 5'd31;
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    checkOutput("t3_we3", 64'(we3), 64'd0);
    checkOutput("t3_count", 64'(wr_count), 64'd1);
    checkOutput("t3_chk_hit", 64'(chk_hit), 64'd0);
    checkOutput("t3_wa3_hold", 64'(wa3), 64'd14);
    checkOutput("t3_wd3_hold", wd3, 64'hFFFF_AAAA_FFFF_CCCC);

    // B write to x7 followed by three idle cycles
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'h77);
    checkOutput("t6_b_ready", 64'(b_ready), 64'd1);
    checkOutput("t6_a_ready", 64'(a_ready), 64'd0);
    tick();
    chk_addr = 5'd7;
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    checkOutput("t6_we3", 64'(we3), 64'd1);
    checkOutput("t6_wa3", 64'(wa3), 64'd7);
    checkOutput("t6_chk_hit", 64'(chk_hit), 64'd1);
    checkOutput("t6_count", 64'(wr_count), 64'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput($sformatf("t6_idle%0d_we3", i), 64'(we3), 64'd0);
      checkOutput($sformatf("t6_idle%0d_wa3", i), 64'(wa3), 64'd7);
      checkOutput($sformatf("t6_idle%0d_wd3", i), wd3, 64'h77);
      checkOutput($sformatf("t6_idle%0d_chk_hit", i), 64'(chk_hit), 64'd0);
    end

    // Both valid for four cycles: grants alternate A,B,A,B
    ai = 0;
    bi = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 5'(1 + ai), 64'hA0 + 64'(1 + ai), 1'b1, 5'(5 + bi), 64'hB0 + 64'(5 + bi));
      checkOutput($sformatf("t2_c%0d_a_ready", i), 64'(a_ready), (i % 2 == 0) ? 64'd1 : 64'd0);
      checkOutput($sformatf("t2_c%0d_b_ready", i), 64'(b_ready), (i % 2 == 0) ? 64'd0 : 64'd1);
      checkOutput($sformatf("t2_c%0d_excl", i), 64'(a_ready && b_ready), 64'd0);
      tick();
      checkOutput($sformatf("t2_c%0d_we3", i), 64'(we3), 64'd1);
      checkOutput($sformatf("t2_c%0d_wa3", i), 64'(wa3), 64'(expWa[i]));
      checkOutput($sformatf("t2_c%0d_wd3", i), wd3, ((i % 2 == 0) ? 64'hA0 : 64'hB0) + 64'(expWa[i]));
      if (i % 2 == 0) ai++;
      else bi++;
    end
    checkOutput("t2_count", 64'(wr_count), 64'd6);

    // B write to x9, then reset the very next cycle
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'h99);
    checkOutput("t4_b_ready", 64'(b_ready), 64'd1);
    tick();
    checkOutput("t4_wa3", 64'(wa3), 64'd9);
    checkOutput("t4_count", 64'(wr_count), 64'd7);
    reset = 1'b1;
    applyStimulus(1'b1, 5'd3, 64'h33, 1'b1, 5'd4, 64'h44);
    checkOutput("t4_rst_a_ready", 64'(a_ready), 64'd0);
    checkOutput("t4_rst_b_ready", 64'(b_ready), 64'd0);
    tick();
    checkOutput("t4_rst_we3", 64'(we3), 64'd0);
    checkOutput("t4_rst_count", 64'(wr_count), 64'd0);
    checkOutput("t4_rst_wa3", 64'(wa3), 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("t4_tie_a_ready", 64'(a_ready), 64'd1);
    checkOutput("t4_tie_b_ready", 64'(b_ready), 64'd0);
    tick();
    checkOutput("t4_tie_wa3", 64'(wa3), 64'd3);
    checkOutput("t4_tie_count", 64'(wr_count), 64'd1);
    applyStimulus(1'b1, 5'd3, 64'h33, 1'b1, 5'd4, 64'h44);
    checkOutput("t4_next_a_ready", 64'(a_ready), 64'd0);
    checkOutput("t4_next_b_ready", 64'(b_ready), 64'd1);
    tick();
    checkOutput("t4_next_wa3", 64'(wa3), 64'd4);
    checkOutput("t4_next_wd3", wd3, 64'h44);
    checkOutput("t4_next_count", 64'(wr_count), 64'd2);

    // Counter saturation from FFFE
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    force dut.count_q = 16'hFFFE;
    #1;
    release dut.count_q;
    #1;
    checkOutput("t5_preload", 64'(wr_count), 64'hFFFE);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'(20 + i), 64'(i), 1'b0, 5'd0, 64'd0);
      tick();
      checkOutput($sformatf("t5_w%0d_count", i), 64'(wr_count), 64'hFFFF);
      checkOutput($sformatf("t5_w%0d_wa3", i), 64'(wa3), 64'(20 + i));
    end
    applyStimulus(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    tick();
    checkOutput("t5_final_count", 64'(wr_count), 64'hFFFF);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
